// File: rtl/uart_alu_ctrl_if.sv
// Bundle of every non-clock, non-reset signal between the UART/ALU sequencer and its
// surroundings (UART receiver/transmitter, baud generator, ALU).
//   master : the sequencer (drives ALU operands, TX request, status and error pulses)
//   slave  : the environment (drives tick, received bytes, TX completion, ALU result)
interface uart_alu_ctrl_if #(
  parameter int unsigned DBIT = 8,
  parameter int unsigned OP_W = 6
);
  logic            s_tick;
  logic            rx_done_tick;
  logic [DBIT-1:0] rx_dout;
  logic            tx_done_tick;
  logic [DBIT-1:0] alu_result;
  logic [DBIT-1:0] alu_a;
  logic [DBIT-1:0] alu_b;
  logic [OP_W-1:0] alu_op;
  logic            tx_start;
  logic [DBIT-1:0] tx_din;
  logic            busy;
  logic            err_timeout;
  logic            err_overrun;

  modport master (
    input  s_tick, rx_done_tick, rx_dout, tx_done_tick, alu_result,
    output alu_a, alu_b, alu_op, tx_start, tx_din, busy, err_timeout, err_overrun
  );

  modport slave (
    output s_tick, rx_done_tick, rx_dout, tx_done_tick, alu_result,
    input  alu_a, alu_b, alu_op, tx_start, tx_din, busy, err_timeout, err_overrun
  );
endinterface

// File: rtl/uart_alu_ctrl.sv
// Sequencer between UART RX/TX and an ALU. Collects operand A, operand B and opcode
// bytes, presents them as registered ALU operands, captures the ALU result and requests
// its transmission. A half-received frame is dropped after TO_TICKS baud ticks without
// a new byte.
// Ports:
//   clk   - system clock, posedge
//   reset - synchronous active-low reset
//   bus   - uart_alu_ctrl_if.master: RX byte/strobe, TX request/done, ALU operands and
//           result, busy flag, timeout/overrun error pulses
module uart_alu_ctrl #(
  parameter int unsigned DBIT     = 8,
  parameter int unsigned OP_W     = 6,
  parameter int unsigned TO_TICKS = 2048
) (
  input logic              clk,
  input logic              reset,
  uart_alu_ctrl_if.master  bus
);

  localparam int unsigned CntW = $clog2(TO_TICKS);
  localparam logic [CntW-1:0] CntMax = CntW'(TO_TICKS - 1);

  typedef enum logic [2:0] {
    StWaitA,
    StWaitB,
    StWaitOp,
    StExec,
    StSend,
    StWaitTx
  } state_e;

  state_e          state_q, state_d;
  logic [DBIT-1:0] alu_a_q, alu_a_d;
  logic [DBIT-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0] alu_op_q, alu_op_d;
  logic [DBIT-1:0] tx_din_q, tx_din_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_timeout_q, err_timeout_d;
  logic            err_overrun_q, err_overrun_d;

  // Opcode bits above OP_W are intentionally dropped.
  logic unused_rx_dout;
  assign unused_rx_dout = ^bus.rx_dout;

  always_comb begin
    state_d       = state_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    tx_din_d      = tx_din_q;
    cnt_d         = cnt_q;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;

    case (state_q)
      StWaitA: begin
        if (bus.rx_done_tick) begin
          alu_a_d = bus.rx_dout;
          cnt_d   = '0;
          state_d = StWaitB;
        end
      end
      StWaitB, StWaitOp: begin
        // A byte arriving on the expiring tick still wins over the timeout.
        if (bus.rx_done_tick) begin
          cnt_d = '0;
          if (state_q == StWaitB) begin
            alu_b_d = bus.rx_dout;
            state_d = StWaitOp;
          end else begin
            alu_op_d = bus.rx_dout[OP_W-1:0];
            state_d  = StExec;
          end
        end else if (bus.s_tick) begin
          if (cnt_q == CntMax) begin
            cnt_d         = '0;
            err_timeout_d = 1'b1;
            state_d       = StWaitA;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StExec: begin
        // Operands have been stable since the opcode was registered last cycle.
        tx_din_d      = bus.alu_result;
        err_overrun_d = bus.rx_done_tick;
        state_d       = StSend;
      end
      StSend: begin
        err_overrun_d = bus.rx_done_tick;
        state_d       = StWaitTx;
      end
      StWaitTx: begin
        err_overrun_d = bus.rx_done_tick;
        if (bus.tx_done_tick) begin
          state_d = StWaitA;
        end
      end
      default: state_d = StWaitA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StWaitA;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      tx_din_q      <= '0;
      cnt_q         <= '0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      tx_din_q      <= tx_din_d;
      cnt_q         <= cnt_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.tx_din      = tx_din_q;
  assign bus.tx_start    = (state_q == StSend);
  assign bus.busy        = (state_q != StWaitA);
  assign bus.err_timeout = err_timeout_q;
  assign bus.err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
module tb_uart_alu_ctrl;
  localparam int unsigned DBIT = 8;
  localparam int unsigned OP_W = 6;
  localparam int unsigned TO   = 16;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  uart_alu_ctrl_if #(.DBIT(DBIT), .OP_W(OP_W)) bus ();

  uart_alu_ctrl #(.DBIT(DBIT), .OP_W(OP_W), .TO_TICKS(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Small ALU: ADD, SUB, AND, OR, XOR; anything else yields zero.
  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    case (op)
      6'h20:   return 8'(a + b);
      6'h22:   return 8'(a - b);
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  always_comb bus.alu_result = ref_alu(bus.alu_a, bus.alu_b, bus.alu_op);

  // Observation log: every transmitted byte and every error pulse.
  logic [7:0] tx_log[$];
  int         n_to = 0;
  int         n_ov = 0;
  always @(negedge clk) begin
    if (bus.tx_start === 1'b1) tx_log.push_back(bus.tx_din);
    if (bus.err_timeout === 1'b1) n_to <= n_to + 1;
    if (bus.err_overrun === 1'b1) n_ov <= n_ov + 1;
  end

  logic [5:0] ops [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h11};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic tick);
    bus.rx_done_tick = 1'b1;
    bus.rx_dout      = b;
    bus.s_tick       = tick;
    step();
    bus.rx_done_tick = 1'b0;
    bus.s_tick       = 1'b0;
    bus.rx_dout      = 8'($urandom);
  endtask

  // Issue exactly n s_tick pulses with random idle cycles in between.
  task automatic tick_gap(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) step();
      bus.s_tick = 1'b1;
      step();
      bus.s_tick = 1'b0;
    end
  endtask

  task automatic pulse_tx_done();
    bus.tx_done_tick = 1'b1;
    step();
    bus.tx_done_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    tests++; if (bus.alu_a !== 8'h00) begin fails++; $display("FAIL reset_alu_a: got %h exp 00", bus.alu_a); end
    tests++; if (bus.alu_b !== 8'h00) begin fails++; $display("FAIL reset_alu_b: got %h exp 00", bus.alu_b); end
    tests++; if (bus.alu_op !== 6'h00) begin fails++; $display("FAIL reset_alu_op: got %h exp 00", bus.alu_op); end
    tests++; if (bus.tx_din !== 8'h00) begin fails++; $display("FAIL reset_tx_din: got %h exp 00", bus.tx_din); end
    tests++; if (bus.tx_start !== 1'b0) begin fails++; $display("FAIL reset_tx_start: got %b exp 0", bus.tx_start); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
    tests++; if ({bus.err_timeout, bus.err_overrun} !== 2'b00) begin fails++; $display("FAIL reset_err: got %b exp 00", {bus.err_timeout, bus.err_overrun}); end
  endtask

  task automatic test_basic();
    send_byte(8'h05, 1'b0);
    tests++; if (bus.alu_a !== 8'h05 || bus.busy !== 1'b1) begin fails++; $display("FAIL basic_a: got a=%h busy=%b exp a=05 busy=1", bus.alu_a, bus.busy); end
    tick_gap($urandom_range(0, TO - 1));
    send_byte(8'h03, 1'b0);
    tests++; if (bus.alu_b !== 8'h03) begin fails++; $display("FAIL basic_b: got %h exp 03", bus.alu_b); end
    tick_gap($urandom_range(0, TO - 1));
    send_byte(8'h20, 1'b0);
    tests++; if (bus.alu_op !== 6'h20 || bus.tx_start !== 1'b0) begin fails++; $display("FAIL basic_exec: got op=%h tx_start=%b exp op=20 tx_start=0", bus.alu_op, bus.tx_start); end
    step();
    tests++; if (bus.tx_start !== 1'b1 || bus.tx_din !== 8'h08) begin fails++; $display("FAIL basic_send: got tx_start=%b din=%h exp 1/08", bus.tx_start, bus.tx_din); end
    step();
    tests++; if (bus.tx_start !== 1'b0 || bus.busy !== 1'b1) begin fails++; $display("FAIL basic_wait_tx: got tx_start=%b busy=%b exp 0/1", bus.tx_start, bus.busy); end
    repeat ($urandom_range(0, 5)) step();
    pulse_tx_done();
    tests++; if (bus.busy !== 1'b0 || bus.tx_din !== 8'h08) begin fails++; $display("FAIL basic_done: got busy=%b din=%h exp 0/08", bus.busy, bus.tx_din); end
  endtask

  task automatic test_timeout();
    int to0;
    to0 = n_to;
    send_byte(8'h11, 1'b0);
    tick_gap(TO - 1);
    tests++; if (bus.busy !== 1'b1 || bus.err_timeout !== 1'b0) begin fails++; $display("FAIL to_early: got busy=%b err=%b exp 1/0", bus.busy, bus.err_timeout); end
    bus.s_tick = 1'b1;
    step();
    bus.s_tick = 1'b0;
    tests++; if (bus.err_timeout !== 1'b1 || bus.busy !== 1'b0) begin fails++; $display("FAIL to_fire: got err=%b busy=%b exp 1/0", bus.err_timeout, bus.busy); end
    tests++; if (bus.alu_a !== 8'h11) begin fails++; $display("FAIL to_stale_a: got %h exp 11", bus.alu_a); end
    step();
    tests++; if (bus.err_timeout !== 1'b0 || n_to - to0 !== 1) begin fails++; $display("FAIL to_single: got err=%b pulses=%0d exp 0/1", bus.err_timeout, n_to - to0); end
    send_byte(8'h02, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h20, 1'b0);
    step();
    tests++; if (bus.tx_start !== 1'b1 || bus.tx_din !== 8'h04) begin fails++; $display("FAIL to_fresh: got tx_start=%b din=%h exp 1/04", bus.tx_start, bus.tx_din); end
    step();
    pulse_tx_done();
    // Timeout while waiting for the opcode.
    send_byte(8'h07, 1'b0);
    send_byte(8'h09, 1'b0);
    tick_gap(TO);
    tests++; if (bus.err_timeout !== 1'b1 || bus.busy !== 1'b0 || bus.alu_b !== 8'h09) begin fails++; $display("FAIL to_op: got err=%b busy=%b b=%h exp 1/0/09", bus.err_timeout, bus.busy, bus.alu_b); end
    step();
  endtask

  task automatic test_coincident();
    logic [7:0] a, b;
    logic [5:0] op;
    int         to0;
    a   = 8'($urandom);
    b   = 8'($urandom);
    op  = ops[$urandom_range(0, 4)];
    to0 = n_to;
    send_byte(a, 1'b0);
    send_byte(b, 1'b0);
    tick_gap(TO - 1);
    send_byte({2'b10, op}, 1'b1);
    tests++; if (bus.err_timeout !== 1'b0 || bus.busy !== 1'b1) begin fails++; $display("FAIL coin_exec: got err=%b busy=%b exp 0/1", bus.err_timeout, bus.busy); end
    step();
    tests++; if (bus.tx_start !== 1'b1 || bus.tx_din !== ref_alu(a, b, op)) begin fails++; $display("FAIL coin_send: got tx_start=%b din=%h exp 1/%h", bus.tx_start, bus.tx_din, ref_alu(a, b, op)); end
    step();
    pulse_tx_done();
    tests++; if (n_to !== to0) begin fails++; $display("FAIL coin_no_to: got %0d pulses exp 0", n_to - to0); end
  endtask

  task automatic test_overrun();
    int n0, ov0;
    ov0 = n_ov;
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h22, 1'b0);
    step();
    step();
    n0 = tx_log.size();
    send_byte(8'hAA, 1'b0);
    tests++; if (bus.err_overrun !== 1'b1 || bus.busy !== 1'b1 || bus.tx_din !== 8'hF0 || bus.alu_a !== 8'h10) begin fails++; $display("FAIL ov_pulse: got err=%b busy=%b din=%h a=%h exp 1/1/f0/10", bus.err_overrun, bus.busy, bus.tx_din, bus.alu_a); end
    step();
    tests++; if (bus.err_overrun !== 1'b0) begin fails++; $display("FAIL ov_single: got %b exp 0", bus.err_overrun); end
    repeat (3) step();
    tests++; if (tx_log.size() !== n0) begin fails++; $display("FAIL ov_no_tx: got %0d extra tx_start exp 0", tx_log.size() - n0); end
    pulse_tx_done();
    send_byte(8'hFF, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h20, 1'b0);
    // Stray byte during EXEC is discarded but flagged.
    send_byte(8'h55, 1'b0);
    tests++; if (bus.tx_start !== 1'b1 || bus.tx_din !== 8'h00 || bus.err_overrun !== 1'b1) begin fails++; $display("FAIL ov_wrap: got tx_start=%b din=%h err=%b exp 1/00/1", bus.tx_start, bus.tx_din, bus.err_overrun); end
    step();
    tests++; if (bus.alu_a !== 8'hFF || n_ov - ov0 !== 2) begin fails++; $display("FAIL ov_count: got a=%h pulses=%0d exp ff/2", bus.alu_a, n_ov - ov0); end
    pulse_tx_done();
  endtask

  task automatic test_reset_mid();
    int n0;
    send_byte(8'h30, 1'b0);
    send_byte(8'h40, 1'b0);
    send_byte(8'h20, 1'b0);
    step();
    step();
    pulse_tx_done();
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    tests++; if ({bus.alu_a, bus.alu_b, bus.tx_din} !== 24'h0 || bus.busy !== 1'b0) begin fails++; $display("FAIL rst_op: got a=%h b=%h din=%h busy=%b exp 0", bus.alu_a, bus.alu_b, bus.tx_din, bus.busy); end
    send_byte(8'h30, 1'b0);
    send_byte(8'h40, 1'b0);
    send_byte(8'h20, 1'b0);
    step();
    step();
    n0 = tx_log.size();
    reset = 1'b0;
    step();
    reset = 1'b1;
    tests++; if ({bus.alu_a, bus.alu_op, bus.tx_din} !== 22'h0 || bus.busy !== 1'b0 || bus.tx_start !== 1'b0) begin fails++; $display("FAIL rst_tx: got a=%h op=%h din=%h busy=%b start=%b exp 0", bus.alu_a, bus.alu_op, bus.tx_din, bus.busy, bus.tx_start); end
    pulse_tx_done();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    repeat (4) step();
    tests++; if (tx_log.size() !== n0) begin fails++; $display("FAIL rst_no_tx: got %0d tx_start exp 0", tx_log.size() - n0); end
    send_byte(8'h20, 1'b0);
    step();
    tests++; if (bus.tx_start !== 1'b1 || bus.tx_din !== 8'h03) begin fails++; $display("FAIL rst_new: got tx_start=%b din=%h exp 1/03", bus.tx_start, bus.tx_din); end
    step();
    pulse_tx_done();
  endtask

  task automatic test_back_to_back();
    int         n0;
    logic [7:0] e1, e2;
    n0 = tx_log.size();
    e1 = ref_alu(8'h0C, 8'h0A, 6'h26);
    e2 = ref_alu(8'h33, 8'h44, 6'h22);
    send_byte(8'h0C, 1'b0);
    send_byte(8'h0A, 1'b0);
    send_byte(8'h26, 1'b0);
    step();
    step();
    pulse_tx_done();
    pulse_tx_done();
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL b2b_idle_done: got busy=%b exp 0", bus.busy); end
    send_byte(8'h33, 1'b0);
    pulse_tx_done();
    tests++; if (bus.busy !== 1'b1 || bus.alu_a !== 8'h33) begin fails++; $display("FAIL b2b_waitb_done: got busy=%b a=%h exp 1/33", bus.busy, bus.alu_a); end
    send_byte(8'h44, 1'b0);
    send_byte(8'h22, 1'b0);
    step();
    step();
    pulse_tx_done();
    tests++; if (tx_log.size() !== n0 + 2) begin fails++; $display("FAIL b2b_count: got %0d exp 2", tx_log.size() - n0); end
    else begin
      tests++; if (tx_log[n0] !== e1 || tx_log[n0+1] !== e2) begin fails++; $display("FAIL b2b_order: got %h,%h exp %h,%h", tx_log[n0], tx_log[n0+1], e1, e2); end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int         base, to0, ov0, exp_to, exp_ov, budget;
    logic [7:0] a, b, opb;
    base   = tx_log.size();
    to0    = n_to;
    ov0    = n_ov;
    exp_to = 0;
    exp_ov = 0;
    for (int i = 0; i < 30; i++) begin
      a   = 8'($urandom);
      b   = 8'($urandom);
      opb = {2'($urandom), ops[$urandom_range(0, 5)]};
      if ($urandom_range(0, 3) == 0) begin
        send_byte(a, 1'b0);
        if ($urandom_range(0, 1) == 1) send_byte(b, 1'b0);
        tick_gap(TO);
        exp_to++;
      end else begin
        send_byte(a, 1'b0);
        tick_gap($urandom_range(0, TO - 1));
        send_byte(b, 1'b0);
        tick_gap($urandom_range(0, TO - 1));
        send_byte(opb, 1'b0);
        exp_q.push_back(ref_alu(a, b, opb[5:0]));
        step();
        step();
        if ($urandom_range(0, 2) == 0) begin
          send_byte(8'($urandom), 1'b0);
          exp_ov++;
        end
        repeat ($urandom_range(0, 3)) step();
        pulse_tx_done();
      end
      if ($urandom_range(0, 3) == 0) pulse_tx_done();
      budget = 0;
      while (bus.busy !== 1'b0 && budget < 8) begin
        step();
        budget++;
      end
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rnd_idle[%0d]: got busy=%b exp 0", i, bus.busy); end
    end
    step();
    tests++; if (tx_log.size() - base !== exp_q.size()) begin fails++; $display("FAIL rnd_tx_count: got %0d exp %0d", tx_log.size() - base, exp_q.size()); end
    else begin
      foreach (exp_q[k]) begin
        tests++; if (tx_log[base+k] !== exp_q[k]) begin fails++; $display("FAIL rnd_tx[%0d]: got %h exp %h", k, tx_log[base+k], exp_q[k]); end
      end
    end
    tests++; if (n_to - to0 !== exp_to) begin fails++; $display("FAIL rnd_timeouts: got %0d exp %0d", n_to - to0, exp_to); end
    tests++; if (n_ov - ov0 !== exp_ov) begin fails++; $display("FAIL rnd_overruns: got %0d exp %0d", n_ov - ov0, exp_ov); end
  endtask

  initial begin
    reset            = 1'b0;
    bus.s_tick       = 1'b0;
    bus.rx_done_tick = 1'b0;
    bus.rx_dout      = 8'h00;
    bus.tx_done_tick = 1'b0;
    test_reset();
    test_basic();
    test_timeout();
    test_coincident();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
